mux2_onein_sync: RTL and testbench

- Glitch-free 2-to-1 bit-stream selector: routes one of two independent input streams (x0, x1) onto a single registered output y.
- Inverse direction of the one-to-two output splitter used in the same front-end path; used where two demodulator/field sources must share one downstream consumer.
- Inputs and select are asynchronous to clk and are synchronized internally.
- Select changes go through a guard (blanking) interval so y never carries a partial mix of both sources.

---
 rtl/mux2_onein_sync.sv | 106 ++++++++++
 tb/tb_mux2_onein_sync.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_onein_sync.sv
// Glitch-free 2-to-1 bit-stream selector. sel, x0 and x1 are synchronized
// internally, and every source change blanks y low for GUARD_CYCLES cycles.
module mux2_onein_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sel,
  input  logic x0,
  input  logic x1,
  output logic y,
  output logic active_sel,
  output logic busy,
  output logic switch_done
);

  localparam logic [0:0] ST_ACTIVE  = 1'b0;
  localparam logic [0:0] ST_GUARD   = 1'b1;
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic [SYNC_STAGES-1:0] r_x0_sync;
  logic [SYNC_STAGES-1:0] r_x1_sync;

  logic [0:0] r_state;
  logic       r_active_sel;
  logic       r_y;
  logic       r_busy;
  logic       r_switch_done;
  logic [7:0] r_guard_cnt;

  logic w_sel_s;
  logic w_x0_s;
  logic w_x1_s;
  logic w_cur_src;
  logic w_new_src;

  // Plain shift chains: nothing may sit between the synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_sync <= '0;
      r_x0_sync  <= '0;
      r_x1_sync  <= '0;
    end else begin
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], sel};
      r_x0_sync  <= {r_x0_sync[SYNC_STAGES-2:0], x0};
      r_x1_sync  <= {r_x1_sync[SYNC_STAGES-2:0], x1};
    end
  end

  assign w_sel_s   = r_sel_sync[SYNC_STAGES-1];
  assign w_x0_s    = r_x0_sync[SYNC_STAGES-1];
  assign w_x1_s    = r_x1_sync[SYNC_STAGES-1];
  assign w_cur_src = r_active_sel ? w_x1_s : w_x0_s;
  assign w_new_src = w_sel_s ? w_x1_s : w_x0_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_ACTIVE;
      r_active_sel  <= 1'b0;
      r_y           <= 1'b0;
      r_busy        <= 1'b0;
      r_switch_done <= 1'b0;
      r_guard_cnt   <= 8'd0;
    end else begin
      r_switch_done <= 1'b0;
      case (r_state)
        ST_ACTIVE: begin
          if (w_sel_s != r_active_sel) begin
            r_state     <= ST_GUARD;
            r_y         <= 1'b0;
            r_busy      <= 1'b1;
            r_guard_cnt <= GUARD_LOAD;
          end else begin
            r_y <= w_cur_src;
          end
        end
        default: begin
          if (r_guard_cnt != 8'd0) begin
            r_guard_cnt <= r_guard_cnt - 8'd1;
            r_y         <= 1'b0;
          end else begin
            // Guard over: commit if the request still differs, otherwise the
            // request bounced back and the old source resumes silently.
            r_state <= ST_ACTIVE;
            r_busy  <= 1'b0;
            if (w_sel_s != r_active_sel) begin
              r_active_sel  <= w_sel_s;
              r_y           <= w_new_src;
              r_switch_done <= 1'b1;
            end else begin
              r_y <= w_cur_src;
            end
          end
        end
      endcase
    end
  end

  assign y           = r_y;
  assign active_sel  = r_active_sel;
  assign busy        = r_busy;
  assign switch_done = r_switch_done;

endmodule

// File: tb/tb_mux2_onein_sync.sv
// Directed bench for mux2_onein_sync: default instance plus two instances
// with SYNC_STAGES=4 and GUARD_CYCLES of 1 and 255.
module tb_mux2_onein_sync;

  logic clk;
  logic reset;
  logic sel, x0, x1;
  logic y, active_sel, busy, switch_done;
  logic p_sel, p_x0, p_x1;
  logic p1_y, p1_active_sel, p1_busy, p1_done;
  logic p2_y, p2_active_sel, p2_busy, p2_done;

  int checks = 0;
  int errors = 0;

  mux2_onein_sync dut (
    .clk(clk), .reset(reset), .sel(sel), .x0(x0), .x1(x1),
    .y(y), .active_sel(active_sel), .busy(busy), .switch_done(switch_done)
  );

  mux2_onein_sync #(.SYNC_STAGES(4), .GUARD_CYCLES(1)) dut_g1 (
    .clk(clk), .reset(reset), .sel(p_sel), .x0(p_x0), .x1(p_x1),
    .y(p1_y), .active_sel(p1_active_sel), .busy(p1_busy), .switch_done(p1_done)
  );

  mux2_onein_sync #(.SYNC_STAGES(4), .GUARD_CYCLES(255)) dut_g255 (
    .clk(clk), .reset(reset), .sel(p_sel), .x0(p_x0), .x1(p_x1),
    .y(p2_y), .active_sel(p2_active_sel), .busy(p2_busy), .switch_done(p2_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 1'b0; x0 = 1'b0; x1 = 1'b0;
    p_sel = 1'b0; p_x0 = 1'b0; p_x1 = 1'b0;
    #1;
    checks++;
    if ({y, active_sel, busy, switch_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {y, active_sel, busy, switch_done});
    end
    checks++;
    if ({p1_y, p1_active_sel, p1_busy, p1_done, p2_y, p2_active_sel, p2_busy, p2_done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_param_outputs got %b want 00000000",
               {p1_y, p1_active_sel, p1_busy, p1_done, p2_y, p2_active_sel, p2_busy, p2_done});
    end
    tick_n(2);
    reset = 1'b0;
    tick();
    checks++;
    if ({y, active_sel, busy, switch_done} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 0000", {y, active_sel, busy, switch_done});
    end
  endtask

  task automatic test_steady();
    logic pat [0:7];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    pat[4] = 1'b0; pat[5] = 1'b0; pat[6] = 1'b0; pat[7] = 1'b0;
    sel = 1'b0;
    x1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x0 = pat[i];
      tick();
      if (i >= 2) begin
        checks++;
        if (y !== pat[i-2]) begin
          errors++;
          $display("FAIL steady_y step %0d got %b want %b", i, y, pat[i-2]);
        end
        checks++;
        if ({active_sel, busy, switch_done} !== 3'b000) begin
          errors++;
          $display("FAIL steady_status step %0d got %b want 000", i, {active_sel, busy, switch_done});
        end
      end
    end
  endtask

  task automatic test_clean_switch();
    logic exp_y, exp_busy, exp_done, exp_act;
    x0 = 1'b0; x1 = 1'b1; sel = 1'b0;
    tick_n(3);
    sel = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_busy = (k >= 3 && k <= 6);
      exp_done = (k == 7);
      exp_act  = (k >= 7);
      exp_y    = (k >= 7);
      checks++;
      if ({y, active_sel, busy, switch_done} !== {exp_y, exp_act, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL clean_switch cycle %0d got y/act/busy/done=%b want %b", k,
                 {y, active_sel, busy, switch_done}, {exp_y, exp_act, exp_busy, exp_done});
      end
    end
    // Return to source 0 for the following scenarios.
    sel = 1'b0;
    tick_n(10);
    checks++;
    if ({active_sel, busy, y} !== 3'b000) begin
      errors++;
      $display("FAIL switch_back got act/busy/y=%b want 000", {active_sel, busy, y});
    end
  endtask

  task automatic test_aborted_switch();
    logic exp_y, exp_busy;
    x0 = 1'b1; x1 = 1'b0; sel = 1'b0;
    tick_n(3);
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_y got %b want 1", y);
    end
    sel = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) sel = 1'b0;
      exp_busy = (k >= 3 && k <= 6);
      exp_y    = !exp_busy;
      checks++;
      if ({y, active_sel, busy, switch_done} !== {exp_y, 1'b0, exp_busy, 1'b0}) begin
        errors++;
        $display("FAIL abort cycle %0d got y/act/busy/done=%b want %b", k,
                 {y, active_sel, busy, switch_done}, {exp_y, 1'b0, exp_busy, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_guard();
    logic exp_y, exp_busy, exp_done, exp_act;
    x0 = 1'b0; x1 = 1'b1; sel = 1'b0;
    tick_n(3);
    sel = 1'b1;
    tick_n(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midguard_busy got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({y, active_sel, busy, switch_done} !== 4'b0000) begin
      errors++;
      $display("FAIL midguard_reset got y/act/busy/done=%b want 0000", {y, active_sel, busy, switch_done});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_busy = (k >= 3 && k <= 6);
      exp_done = (k == 7);
      exp_act  = (k >= 7);
      exp_y    = (k >= 7);
      checks++;
      if ({y, active_sel, busy, switch_done} !== {exp_y, exp_act, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL after_reset_switch cycle %0d got %b want %b", k,
                 {y, active_sel, busy, switch_done}, {exp_y, exp_act, exp_busy, exp_done});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_y, exp_busy, exp_done, exp_act;
    int done_cnt;
    int overlap;
    reset = 1'b1; sel = 1'b0; x0 = 1'b1; x1 = 1'b1;
    tick();
    reset = 1'b0;
    tick_n(3);
    done_cnt = 0;
    overlap = 0;
    sel = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 8) sel = 1'b0;
      if (switch_done === 1'b1) done_cnt++;
      if (switch_done === 1'b1 && busy === 1'b1) overlap++;
      exp_busy = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
      exp_done = (k == 7) || (k == 15);
      exp_act  = (k >= 7 && k <= 14);
      exp_y    = !exp_busy;
      checks++;
      if ({y, active_sel, busy, switch_done} !== {exp_y, exp_act, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", k,
                 {y, active_sel, busy, switch_done}, {exp_y, exp_act, exp_busy, exp_done});
      end
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_done_pulses got %0d want 2", done_cnt);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL b2b_busy_done_overlap got %0d want 0", overlap);
    end
  endtask

  task automatic test_param_sweep();
    int low1, low2, first1, first2, done1, done2;
    p_sel = 1'b0; p_x0 = 1'b0; p_x1 = 1'b0;
    tick_n(5);
    p_x0 = 1'b1;
    tick_n(4);
    checks++;
    if ({p1_y, p2_y} !== 2'b00) begin
      errors++;
      $display("FAIL latency_cycle4 got %b want 00", {p1_y, p2_y});
    end
    tick();
    checks++;
    if ({p1_y, p2_y} !== 2'b11) begin
      errors++;
      $display("FAIL latency_cycle5 got %b want 11", {p1_y, p2_y});
    end
    p_x1 = 1'b1;
    tick_n(6);
    low1 = 0; low2 = 0; first1 = -1; first2 = -1; done1 = 0; done2 = 0;
    p_sel = 1'b1;
    for (int k = 1; k <= 270; k++) begin
      tick();
      if (p1_y === 1'b0) begin low1++; if (first1 < 0) first1 = k; end
      if (p2_y === 1'b0) begin low2++; if (first2 < 0) first2 = k; end
      if (p1_done === 1'b1) done1++;
      if (p2_done === 1'b1) done2++;
    end
    checks++;
    if (low1 != 1 || first1 != 5) begin
      errors++;
      $display("FAIL blank_g1 got len %0d start %0d want len 1 start 5", low1, first1);
    end
    checks++;
    if (low2 != 255 || first2 != 5) begin
      errors++;
      $display("FAIL blank_g255 got len %0d start %0d want len 255 start 5", low2, first2);
    end
    checks++;
    if (done1 != 1 || done2 != 1 || {p1_active_sel, p2_active_sel, p1_busy, p2_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL param_commit got done %0d/%0d act/busy %b want 1/1 1100", done1, done2,
               {p1_active_sel, p2_active_sel, p1_busy, p2_busy});
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_clean_switch();
    test_aborted_switch();
    test_reset_mid_guard();
    test_back_to_back();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
